// File: rtl/fp_convert_seq_pkg.sv
// Shared constants and state encoding for the 12-bit sample to 8-bit float converter.
package fp_conv_pkg;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;

    localparam logic [EXP_W-1:0]  E_MAX   = 3'd7;
    localparam logic [FRAC_W-1:0] F_MAX   = 4'd15;
    localparam logic [FRAC_W-1:0] F_CARRY = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp_convert_seq_if.sv
// Sample-in / float-out handshake bundle; the converter sits on the slave side.
interface fp_convert_seq_if
    import fp_conv_pkg::*;
();

    logic [DATA_W-1:0] d;
    logic              in_valid;
    logic              in_ready;
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output d, in_valid, out_ready,
        input  in_ready, s, e, f, out_valid
    );

    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, s, e, f, out_valid
    );

endinterface

// File: rtl/fp_convert_seq_split.sv
// Splits a two's-complement sample into sign and 12-bit magnitude (0x800 stays 0x800).
module sign_mag_split
    import fp_conv_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic              sign,
    output logic [DATA_W-1:0] mag
);

    assign sign = d[DATA_W-1];
    assign mag  = sign ? (~d + DATA_W'(1)) : d;

endmodule

// File: rtl/fp_convert_seq.sv
// Sequencer: accept a sample, normalise one bit per cycle, round, then hold the result until taken.
module fp_convert_seq
    import fp_conv_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_convert_seq_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              sign_q, sign_d;
    logic              s_q, s_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [FRAC_W-1:0] f_q, f_d;

    logic              split_sign;
    logic [DATA_W-1:0] split_mag;
    logic [FRAC_W-1:0] f_raw;
    logic              round_bit;

    sign_mag_split u_split (
        .d    (bus.d),
        .sign (split_sign),
        .mag  (split_mag)
    );

    assign f_raw     = mag_q[10:7];
    assign round_bit = mag_q[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            sign_q  <= 1'b0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            sign_q  <= sign_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        sign_d  = sign_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = split_sign;
                    mag_d   = split_mag;
                    cnt_d   = E_MAX;
                    sat_d   = 1'b0;
                    state_d = NORM;
                end
            end

            NORM: begin
                // Only -2048 has bit 11 set after the split; it cannot be represented.
                if (mag_q[11]) begin
                    sat_d   = 1'b1;
                    state_d = ROUND;
                end else if (mag_q[10] || (cnt_q == '0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - 3'd1;
                end
            end

            ROUND: begin
                s_d     = sign_q;
                e_d     = cnt_q;
                f_d     = f_raw;
                state_d = DONE;
                if (sat_q) begin
                    e_d = E_MAX;
                    f_d = F_MAX;
                end else if (ROUND_EN && round_bit) begin
                    // A carry out of F renormalises to 1000 with one more exponent step.
                    if (f_raw != F_MAX) begin
                        f_d = f_raw + 4'd1;
                    end else if (cnt_q != E_MAX) begin
                        e_d = cnt_q + 3'd1;
                        f_d = F_CARRY;
                    end else begin
                        e_d = E_MAX;
                        f_d = F_MAX;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.e         = e_q;
    assign bus.f         = f_q;

endmodule
